// File: rtl/ic_pkg.sv
// Shared definitions for the timer input-capture unit: edge-select encodings,
// default data width and the edge-select decode helper.
package ic_pkg;

    localparam int unsigned IC_CNT_W = 16;

    localparam logic [1:0] IC_EDGE_RISE = 2'b00;
    localparam logic [1:0] IC_EDGE_FALL = 2'b01;
    localparam logic [1:0] IC_EDGE_BOTH = 2'b10;

    // Encoding 2'b11 is treated as rising, same as IC_EDGE_RISE.
    function automatic logic ic_edge_pick(input logic [1:0] sel,
                                          input logic       rise,
                                          input logic       fall);
        logic hit;
        case (sel)
            IC_EDGE_FALL: hit = fall;
            IC_EDGE_BOTH: hit = rise | fall;
            default:      hit = rise;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ic_fifo.sv
// Capture FIFO: synchronous push/pop/clear with a registered head word that
// reads 0 when empty. A push into a full FIFO is accepted only with a pop.
module ic_fifo
    import ic_pkg::*;
#(
    parameter int unsigned DATA_W = IC_CNT_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              ne_q, ne_d;

    logic full, empty, do_push, do_pop;

    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == CW'(DEPTH));
        do_pop  = pop_i & ~empty & ~clr_i;
        // When full, a same-cycle pop frees the slot the push lands in.
        do_push = push_i & ~clr_i & (~full | do_pop);
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        head_d   = head_q;

        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            head_d   = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase

            // The new head may be the word being written this cycle.
            if (cnt_d == '0) begin
                head_d = '0;
            end else if (empty || (do_pop && (cnt_q == CW'(1)))) begin
                head_d = wdata_i;
            end else if (do_pop) begin
                head_d = mem_q[rd_ptr_d];
            end
        end

        ne_d = (cnt_d != '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
            ne_q     <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
            ne_q     <= ne_d;
        end
    end

    assign head_o  = head_q;
    assign full_o  = full;
    assign empty_o = ~ne_q;

endmodule

// File: rtl/input_capture.sv
// Timer input capture: pin synchroniser, optional noise filter (IC_NOISE_CANCEL_EN),
// edge select and enable gating feeding a snapshot FIFO of counter values.
module input_capture
    import ic_pkg::*;
#(
    parameter int unsigned CNT_W       = IC_CNT_W,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_sysclk,
    input  logic             i_sysrst_n,
    input  logic             i_cap_en,
    input  logic             i_cap_clr,
    input  logic [1:0]       i_cap_edge,
    input  logic             i_cap_pin,
    input  logic [CNT_W-1:0] i_cnt_data,
    input  logic             i_cap_rd,
    output logic             o_cap_ic_flg,
    output logic [CNT_W-1:0] o_cap_cnt_data,
    output logic             o_cap_ne,
    output logic             o_cap_ovr
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   p_pin_q, p_pin_d;
    logic                   evt_q, evt_d;
    logic                   en_q, en_d;
    logic                   ovr_q, ovr_d;

    logic s_pin, lvl, rise, fall, accept;
    logic fifo_full, fifo_empty;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_cap_pin};
        s_pin  = sync_q[SYNC_STAGES-1];
    end

`ifdef IC_NOISE_CANCEL_EN
    logic [2:0] filt_hist_q, filt_hist_d;
    logic       filt_q, filt_d;

    // Level follows s_pin only once the current and three previous samples agree.
    always_comb begin
        filt_hist_d = {filt_hist_q[1:0], s_pin};
        if (&{filt_hist_q, s_pin}) begin
            lvl = 1'b1;
        end else if (~|{filt_hist_q, s_pin}) begin
            lvl = 1'b0;
        end else begin
            lvl = filt_q;
        end
        filt_d = lvl;
    end

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            filt_hist_q <= '0;
            filt_q      <= 1'b0;
        end else begin
            filt_hist_q <= filt_hist_d;
            filt_q      <= filt_d;
        end
    end
`else
    assign lvl = s_pin;
`endif

    always_comb begin
        rise    = lvl & ~p_pin_q;
        fall    = ~lvl & p_pin_q;
        p_pin_d = lvl;
        evt_d   = ic_edge_pick(i_cap_edge, rise, fall);
        en_d    = i_cap_en;

        // Enable must have been high last cycle too, so edges that arrived while
        // disabled are not captured on the enabling cycle; clear wins outright.
        accept = evt_q & i_cap_en & en_q & ~i_cap_clr;

        ovr_d = ovr_q;
        if (i_cap_clr) begin
            ovr_d = 1'b0;
        end else if (accept && fifo_full && !i_cap_rd) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            sync_q  <= '0;
            p_pin_q <= 1'b0;
            evt_q   <= 1'b0;
            en_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            p_pin_q <= p_pin_d;
            evt_q   <= evt_d;
            en_q    <= en_d;
            ovr_q   <= ovr_d;
        end
    end

    ic_fifo #(
        .DATA_W (CNT_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_sysclk),
        .rst_ni  (i_sysrst_n),
        .push_i  (accept),
        .pop_i   (i_cap_rd),
        .clr_i   (i_cap_clr),
        .wdata_i (i_cnt_data),
        .head_o  (o_cap_cnt_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign o_cap_ic_flg = accept;
    assign o_cap_ne     = ~fifo_empty;
    assign o_cap_ovr    = ovr_q;

endmodule

// File: tb/tb_input_capture.sv
// Self-checking bench for input_capture (default build): directed scenarios plus
// random traffic, checked every cycle against a pin-delay and queue reference model.
module tb_input_capture;
    import ic_pkg::*;

    localparam int unsigned CW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int          MAXC  = 4096;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b0;
    logic          clr   = 1'b0;
    logic          pin   = 1'b0;
    logic          rd    = 1'b0;
    logic [1:0]    esel  = 2'b00;
    logic [CW-1:0] cnt   = '0;

    logic          flg, ne, ovr;
    logic [CW-1:0] dout;

    input_capture #(
        .CNT_W       (CW),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .i_sysclk       (clk),
        .i_sysrst_n     (rst_n),
        .i_cap_en       (en),
        .i_cap_clr      (clr),
        .i_cap_edge     (esel),
        .i_cap_pin      (pin),
        .i_cnt_data     (cnt),
        .i_cap_rd       (rd),
        .o_cap_ic_flg   (flg),
        .o_cap_cnt_data (dout),
        .o_cap_ne       (ne),
        .o_cap_ovr      (ovr)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: per-cycle input history plus a queue of stored values.
    int         cyc;
    int         floor_c;
    logic       pin_h  [MAXC];
    logic       en_h   [MAXC];
    logic [1:0] edge_h [MAXC];
    int         q[$];
    logic       m_ovr;
    int         flag_seen;
    int         last_flag_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Pin level as seen by the design; anything before the last reset reads 0.
    function automatic logic hp(input int t);
        return (t < floor_c) ? 1'b0 : pin_h[t];
    endfunction

    function automatic logic he(input int t);
        return (t < floor_c) ? 1'b0 : en_h[t];
    endfunction

    // Edge of interest seen in cycle u: pin transition two/three cycles earlier.
    function automatic logic ev(input int u);
        logic s, p;
        s = hp(u - 2);
        p = hp(u - 3);
        case (edge_h[u])
            IC_EDGE_FALL: return ~s & p;
            IC_EDGE_BOTH: return s ^ p;
            default:      return s & ~p;
        endcase
    endfunction

    task automatic step(input logic p, input logic e, input logic [1:0] es,
                        input logic c, input logic r);
        logic exp_flag;
        int   exp_head;
        pin  = p;
        en   = e;
        esel = es;
        clr  = c;
        rd   = r;
        cnt  = cnt + 16'($urandom_range(1, 3));
        pin_h[cyc]  = p;
        en_h[cyc]   = e;
        edge_h[cyc] = es;
        exp_flag = ev(cyc - 1) & e & he(cyc - 1) & ~c;
        exp_head = (q.size() > 0) ? q[0] : 0;

        @(negedge clk);
        chk("flag", 32'(flg), 32'(exp_flag));
        chk("data", 32'(dout), exp_head);
        chk("ne", 32'(ne), 32'(q.size() > 0));
        chk("ovr", 32'(ovr), 32'(m_ovr));
        if (flg === 1'b1) begin
            flag_seen++;
            last_flag_cyc = cyc;
        end

        if (c) begin
            q.delete();
            m_ovr = 1'b0;
        end else begin
            if (r && q.size() > 0) begin
                void'(q.pop_front());
            end
            if (exp_flag) begin
                if (q.size() < int'(DEPTH)) begin
                    q.push_back(int'(cnt));
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic p, input logic e, input logic [1:0] es);
        for (int i = 0; i < n; i++) begin
            step(p, e, es, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic pv;
        int   f0;
        int   pc;

        for (int i = 0; i < MAXC; i++) begin
            pin_h[i]  = 1'b0;
            en_h[i]   = 1'b0;
            edge_h[i] = 2'b00;
        end
        q.delete();
        m_ovr         = 1'b0;
        flag_seen     = 0;
        last_flag_cyc = 0;

        // Reset state
        #2;
        chk("rst_flag", 32'(flg), 0);
        chk("rst_data", 32'(dout), 0);
        chk("rst_ne", 32'(ne), 0);
        chk("rst_ovr", 32'(ovr), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        cyc     = 10;
        floor_c = 10;

        // Rising capture and its latency
        idle(4, 1'b0, 1'b1, IC_EDGE_RISE);
        pc = cyc;
        idle(8, 1'b1, 1'b1, IC_EDGE_RISE);
        chk("rise_lat", last_flag_cyc - pc, 3);
        step(1'b1, 1'b1, IC_EDGE_RISE, 1'b0, 1'b1);
        idle(2, 1'b1, 1'b1, IC_EDGE_RISE);

        // Both edges, five toggles into a four-deep FIFO
        pv = 1'b1;
        f0 = flag_seen;
        for (int i = 0; i < 5; i++) begin
            pv = ~pv;
            idle(4, pv, 1'b1, IC_EDGE_BOTH);
        end
        idle(3, pv, 1'b1, IC_EDGE_BOTH);
        chk("both_flags", flag_seen - f0, 5);
        chk("both_ovr", 32'(ovr), 1);
        for (int i = 0; i < 4; i++) begin
            step(pv, 1'b1, IC_EDGE_BOTH, 1'b0, 1'b1);
            step(pv, 1'b1, IC_EDGE_BOTH, 1'b0, 1'b0);
        end
        chk("drain_ne", 32'(ne), 0);
        step(pv, 1'b1, IC_EDGE_BOTH, 1'b1, 1'b0);
        idle(1, pv, 1'b1, IC_EDGE_BOTH);

        // Clear in the same cycle as an accepted event
        for (int i = 0; i < 2; i++) begin
            pv = ~pv;
            idle(4, pv, 1'b1, IC_EDGE_BOTH);
        end
        chk("pre_clr_ne", 32'(ne), 1);
        f0 = flag_seen;
        pv = ~pv;
        idle(3, pv, 1'b1, IC_EDGE_BOTH);
        step(pv, 1'b1, IC_EDGE_BOTH, 1'b1, 1'b0);
        idle(2, pv, 1'b1, IC_EDGE_BOTH);
        chk("clr_noflag", flag_seen - f0, 0);
        chk("clr_ne", 32'(ne), 0);
        chk("clr_data", 32'(dout), 0);

        // Enable gating: stale rise ignored, next falling edge captured
        idle(3, 1'b0, 1'b0, IC_EDGE_RISE);
        idle(6, 1'b1, 1'b0, IC_EDGE_RISE);
        f0 = flag_seen;
        idle(6, 1'b1, 1'b1, IC_EDGE_RISE);
        chk("gate_stale", flag_seen - f0, 0);
        idle(6, 1'b0, 1'b1, IC_EDGE_FALL);
        chk("gate_fall", flag_seen - f0, 1);
        step(1'b0, 1'b1, IC_EDGE_FALL, 1'b0, 1'b1);

        // Three-cycle pulse (no filter in this build)
        f0 = flag_seen;
        idle(3, 1'b1, 1'b1, IC_EDGE_RISE);
        idle(4, 1'b0, 1'b1, IC_EDGE_RISE);
        chk("pulse3", flag_seen - f0, 1);
        step(1'b0, 1'b1, IC_EDGE_RISE, 1'b0, 1'b1);

        // Random traffic
        pv = 1'b0;
        for (int i = 0; i < 120; i++) begin
            int hold;
            logic [1:0] es;
            hold = $urandom_range(1, 6);
            es   = 2'($urandom_range(0, 3));
            pv   = ~pv;
            for (int j = 0; j < hold; j++) begin
                step(pv, ($urandom_range(0, 9) != 0), es,
                     ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) == 0));
            end
        end

        // Reset with three entries queued
        step(pv, 1'b1, IC_EDGE_BOTH, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pv = ~pv;
            idle(4, pv, 1'b1, IC_EDGE_BOTH);
        end
        idle(2, pv, 1'b1, IC_EDGE_BOTH);
        chk("pre_rst_ne", 32'(ne), 1);
        rst_n = 1'b0;
        #2;
        chk("arst_flag", 32'(flg), 0);
        chk("arst_data", 32'(dout), 0);
        chk("arst_ne", 32'(ne), 0);
        chk("arst_ovr", 32'(ovr), 0);
        repeat (2) @(posedge clk);
        #1;
        cyc     = cyc + 2;
        rst_n   = 1'b1;
        floor_c = cyc;
        q.delete();
        m_ovr = 1'b0;
        idle(6, pv, 1'b1, IC_EDGE_BOTH);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
